tri_writer: RTL and testbench
=============================

TRI_WRITER -- requirements
Module: tri_writer

Interface
REQ-001 SHALL have parameter NDWORDS, default 9: number of 32-bit words per block.
REQ-002 SHALL have localparam BLOCKSZ = 32*NDWORDS: block width in bits.
REQ-003 SHALL have `clk`  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have `reset`  input  1: synchronous, active-high reset.
REQ-005 SHALL have `baseaddr`  input  32: block-array base, 16-bit halfword units; constant during operation.
REQ-006 SHALL have `index`  input  32: block index; sampled on accept.
REQ-007 SHALL have `data`  input  BLOCKSZ: block payload; word k = data[32k+31:32k]; sampled on accept.
REQ-008 SHALL have `write`  input  1: request valid.
REQ-009 SHALL have `iready`  output  1: ready to accept a request.
REQ-010 SHALL have `done`  output  1: one-cycle pulse when the last halfword is accepted by memory.
REQ-011 SHALL have `avm_m0_write`  output  1, `avm_m0_address`  output  32, `avm_m0_writedata`  output  16, and `avm_m0_byteenable`  output  2 (constant 2'b11).
REQ-012 SHALL have `avm_m0_waitrequest`  input  1.
REQ-013 SHALL have `avm_m0_read`  output  1 (tied 0), `avm_m0_readdata`  input  16 (unused) and `avm_m0_readdatavalid`  input  1 (unused).

Function
REQ-014 SHALL accept a request in any cycle where write && iready; index, data and baseaddr+2*NDWORDS*index are registered at that edge.
REQ-015 SHALL compute addresses in 32-bit arithmetic, wrapping modulo 2^32.
REQ-016 SHALL emit 2*NDWORDS beats; beat j writes address start+j; even j carries the low half of word j/2, odd j the high half.
REQ-017 SHALL implement an FSM of three states. IDLE: iready=1, avm_m0_write=0, -> WRITE on accept. WRITE: avm_m0_write=1, iready=0. DONE: done=1, iready=0, -> IDLE unconditionally.
REQ-018 SHALL count a beat as accepted only in a cycle where avm_m0_write=1 and avm_m0_waitrequest=0; the beat counter and data shift then advance at that edge.
REQ-019 SHALL hold avm_m0_address and avm_m0_writedata stable, and keep avm_m0_write asserted, while avm_m0_waitrequest=1.
REQ-020 SHALL go WRITE -> DONE on acceptance of beat 2*NDWORDS-1.
REQ-021 SHALL have this latency with no waitrequest: accept at T, beats T+1..T+2*NDWORDS, done at T+2*NDWORDS+1, iready at T+2*NDWORDS+2; each waitrequest cycle adds one cycle.
REQ-022 SHALL ignore write while iready=0, with no capture and no state effect; the requester holds write, index and data until accepted.
REQ-023 SHALL accept a request held continuously high in the first IDLE cycle after DONE, giving one idle gap between blocks.
REQ-024 SHALL use a beat counter of width $clog2(2*NDWORDS) with no wrap inside a block; the counter resets to 0 on accept.

Reset
REQ-025 SHALL, on reset, drive state=IDLE, avm_m0_write=0, done=0, iready=1 and counter=0 from the next edge; data and address registers are don't-care.
REQ-026 SHALL let reset mid-block abort the block: avm_m0_write drops at the next edge, there is no done pulse, and already-written halfwords remain in memory.
REQ-027 SHALL give reset priority over a simultaneous write; no accept occurs in a reset cycle.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, WRITE, DONE) and the default NDWORDS=9 in shared package tri_mem_pkg, shared with the reader side.
REQ-029 SHALL be a single module with no sub-module; the serializer is a BLOCKSZ-bit shift register that shifts 16 bits per accepted beat, and writedata is its low 16 bits.

Verification
REQ-030 SHALL cover: NDWORDS=9, baseaddr=0x1000, index=2, word0=0xDEADBEEF, no waitrequest -> beat0 at 0x1024 with 0xBEEF, beat1 at 0x1025 with 0xDEAD, 18 beats, done at T+19.
REQ-031 SHALL cover: waitrequest high for 3 cycles on beat 5 -> address/data/write stable those 3 cycles, done at T+22, no dropped or duplicated beat.
REQ-032 SHALL cover: new write with index=7 pulsed during WRITE -> ignored; the request is accepted only after done when write is held; the next beat0 is at baseaddr+126.
REQ-033 SHALL cover: reset asserted after beat 7 is accepted -> avm_m0_write=0 and iready=1 on the next cycle, done never pulses.
REQ-034 SHALL cover: baseaddr=0xFFFFFFF0, index=0 -> beat 15 at 0xFFFFFFFF, beat 16 at 0x00000000, beat 17 at 0x00000001.
REQ-035 SHALL cover: write held high for two blocks -> exactly one idle cycle with iready=1 between done and the second beat0.

Source files
------------

// File: rtl/tri_mem_pkg.sv
// Shared definitions for the tri-memory block reader/writer pair.
// Holds the block FSM state encoding and the default block size.
package tri_mem_pkg;

  localparam int TRI_NDWORDS_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } tri_state_t;

endpackage

// File: rtl/tri_writer.sv
// Serializes one block of NDWORDS 32-bit words into 2*NDWORDS consecutive
// 16-bit Avalon-MM writes starting at baseaddr + 2*NDWORDS*index.
module tri_writer
  import tri_mem_pkg::*;
#(
  parameter  int NDWORDS = TRI_NDWORDS_DEFAULT,
  localparam int BLOCKSZ = 32 * NDWORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        baseaddr,
  input  logic [31:0]        index,
  input  logic [BLOCKSZ-1:0] data,
  input  logic               write,
  output logic               iready,
  output logic               done,
  output logic               avm_m0_write,
  output logic [31:0]        avm_m0_address,
  output logic [15:0]        avm_m0_writedata,
  output logic [1:0]         avm_m0_byteenable,
  input  logic               avm_m0_waitrequest,
  output logic               avm_m0_read,
  input  logic [15:0]        avm_m0_readdata,
  input  logic               avm_m0_readdatavalid
);

  localparam int NBEATS = 2 * NDWORDS;
  localparam int CW     = $clog2(NBEATS);

  tri_state_t         state_reg, state_next;
  logic [CW-1:0]      beat_reg;
  logic [BLOCKSZ-1:0] shift_reg;
  logic [31:0]        addr_reg;

  logic accept;
  logic beat_ack;
  logic last_beat;

  // The read channel belongs to the reader side; these inputs are only tied off here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, avm_m0_readdata, avm_m0_readdatavalid};

  assign accept    = write && iready;
  assign beat_ack  = avm_m0_write && !avm_m0_waitrequest;
  assign last_beat = (beat_reg == CW'(NBEATS - 1));

  assign avm_m0_address    = addr_reg;
  assign avm_m0_writedata  = shift_reg[15:0];
  assign avm_m0_byteenable = 2'b11;
  assign avm_m0_read       = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        beat_reg <= '0;
      end else if (beat_ack) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  // Payload and address need no reset: they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= data;
      addr_reg  <= baseaddr + index * 32'(NBEATS);
    end else if (beat_ack) begin
      shift_reg <= shift_reg >> 16;
      addr_reg  <= addr_reg + 32'd1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    iready       = 1'b0;
    avm_m0_write = 1'b0;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        iready = 1'b1;
        if (write) state_next = WRITE;
      end
      WRITE: begin
        avm_m0_write = 1'b1;
        if (beat_ack && last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tri_writer.sv
// Directed bench for tri_writer: logs bus beats, done pulses and accepts per
// cycle, then each scenario task checks the log against hand-derived values.
module tb_tri_writer;

  localparam int NDW = 9;
  localparam int BLK = 32 * NDW;
  localparam int NB  = 2 * NDW;

  logic           clk;
  logic           reset;
  logic [31:0]    baseaddr;
  logic [31:0]    index;
  logic [BLK-1:0] data;
  logic           write;
  logic           iready;
  logic           done;
  logic           avm_m0_write;
  logic [31:0]    avm_m0_address;
  logic [15:0]    avm_m0_writedata;
  logic [1:0]     avm_m0_byteenable;
  logic           avm_m0_waitrequest;
  logic           avm_m0_read;
  logic [15:0]    avm_m0_readdata;
  logic           avm_m0_readdatavalid;

  tri_writer #(.NDWORDS(NDW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .baseaddr            (baseaddr),
    .index               (index),
    .data                (data),
    .write               (write),
    .iready              (iready),
    .done                (done),
    .avm_m0_write        (avm_m0_write),
    .avm_m0_address      (avm_m0_address),
    .avm_m0_writedata    (avm_m0_writedata),
    .avm_m0_byteenable   (avm_m0_byteenable),
    .avm_m0_waitrequest  (avm_m0_waitrequest),
    .avm_m0_read         (avm_m0_read),
    .avm_m0_readdata     (avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [31:0] beat_addr[$];
  logic [15:0] beat_data[$];
  int          beat_cyc[$];
  int          done_cyc[$];
  int          acc_cyc[$];

  function automatic logic [BLK-1:0] make_data(input logic [7:0] seed);
    logic [BLK-1:0] d;
    d = '0;
    for (int k = 0; k < NDW; k++) d[32*k +: 32] = {8'hA0, seed, 8'h50, 8'(k)};
    return d;
  endfunction

  task automatic clear_log();
    beat_addr.delete(); beat_data.delete(); beat_cyc.delete();
    done_cyc.delete(); acc_cyc.delete();
  endtask

  // Log what the current cycle will commit at the coming edge, then advance.
  task automatic step();
    if (avm_m0_write && !avm_m0_waitrequest) begin
      beat_addr.push_back(avm_m0_address);
      beat_data.push_back(avm_m0_writedata);
      beat_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (write && iready && !reset) acc_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b1; index = 32'd5;
    step(); step();
    tests_run++;
    if (iready !== 1'b1) begin tests_failed++; $display("FAIL reset_iready got=%b exp=1", iready); end
    tests_run++;
    if (avm_m0_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write got=%b exp=0", avm_m0_write); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++;
    if (avm_m0_read !== 1'b0 || avm_m0_byteenable !== 2'b11) begin
      tests_failed++; $display("FAIL reset_ties got read=%b be=%b exp read=0 be=11", avm_m0_read, avm_m0_byteenable);
    end
    tests_run++;
    if (acc_cyc.size() != 0) begin tests_failed++; $display("FAIL reset_priority accepts=%0d exp=0", acc_cyc.size()); end
    write = 1'b0; reset = 1'b0;
    step();
    $display("[TB] test_reset complete");
  endtask

  task automatic test_basic();
    logic [BLK-1:0] blk;
    int t;
    clear_log();
    blk = make_data(8'h01);
    blk[31:0] = 32'hDEAD_BEEF;
    baseaddr = 32'h0000_1000; index = 32'd2; data = blk; write = 1'b1;
    t = cyc;
    step();
    write = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      if (i >= 1 && i <= NB) begin
        tests_run++;
        if (iready !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_iready cyc=T+%0d got=%b exp=0", i, iready); end
      end
      if (i == NB + 2) begin
        tests_run++;
        if (iready !== 1'b1) begin tests_failed++; $display("FAIL basic_iready_back got=%b exp=1", iready); end
      end
      step();
    end
    tests_run++;
    if (beat_addr.size() != NB) begin
      tests_failed++; $display("FAIL basic_beat_count got=%0d exp=%0d", beat_addr.size(), NB);
    end else begin
      tests_run++;
      if (beat_addr[0] !== 32'h0000_1024 || beat_data[0] !== 16'hBEEF) begin
        tests_failed++; $display("FAIL basic_beat0 got=%h/%h exp=00001024/beef", beat_addr[0], beat_data[0]);
      end
      tests_run++;
      if (beat_addr[1] !== 32'h0000_1025 || beat_data[1] !== 16'hDEAD) begin
        tests_failed++; $display("FAIL basic_beat1 got=%h/%h exp=00001025/dead", beat_addr[1], beat_data[1]);
      end
      for (int j = 0; j < NB; j++) begin
        tests_run++;
        if (beat_addr[j] !== 32'h0000_1024 + 32'(j) || beat_data[j] !== blk[16*j +: 16] || beat_cyc[j] != t + 1 + j) begin
          tests_failed++;
          $display("FAIL basic_beat%0d got=%h/%h@%0d exp=%h/%h@%0d", j, beat_addr[j], beat_data[j],
                   beat_cyc[j] - t, 32'h0000_1024 + 32'(j), blk[16*j +: 16], 1 + j);
        end
      end
    end
    tests_run++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 19) begin
      tests_failed++; $display("FAIL basic_done pulses=%0d first=T+%0d exp=1@T+19", done_cyc.size(),
                               done_cyc.size() > 0 ? done_cyc[0] - t : -1);
    end
    $display("[TB] test_basic complete: %0d beats", beat_addr.size());
  endtask

  task automatic test_waitrequest();
    logic [BLK-1:0] blk;
    int t;
    clear_log();
    blk = make_data(8'h02);
    baseaddr = 32'h0000_1000; index = 32'd2; data = blk; write = 1'b1;
    t = cyc;
    step();
    write = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      avm_m0_waitrequest = (i >= 6 && i <= 8);
      if (i >= 6 && i <= 9) begin
        tests_run++;
        if (avm_m0_write !== 1'b1 || avm_m0_address !== 32'h0000_1029 || avm_m0_writedata !== blk[16*5 +: 16]) begin
          tests_failed++;
          $display("FAIL wait_hold cyc=T+%0d got=%b/%h/%h exp=1/00001029/%h", i, avm_m0_write, avm_m0_address,
                   avm_m0_writedata, blk[16*5 +: 16]);
        end
      end
      step();
    end
    avm_m0_waitrequest = 1'b0;
    tests_run++;
    if (beat_addr.size() != NB) begin
      tests_failed++; $display("FAIL wait_beat_count got=%0d exp=%0d", beat_addr.size(), NB);
    end else begin
      for (int j = 0; j < NB; j++) begin
        tests_run++;
        if (beat_addr[j] !== 32'h0000_1024 + 32'(j) || beat_data[j] !== blk[16*j +: 16]) begin
          tests_failed++;
          $display("FAIL wait_beat%0d got=%h/%h exp=%h/%h", j, beat_addr[j], beat_data[j],
                   32'h0000_1024 + 32'(j), blk[16*j +: 16]);
        end
      end
      tests_run++;
      if (beat_cyc[5] != t + 9) begin tests_failed++; $display("FAIL wait_beat5_cycle got=T+%0d exp=T+9", beat_cyc[5] - t); end
    end
    tests_run++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 22) begin
      tests_failed++; $display("FAIL wait_done pulses=%0d first=T+%0d exp=1@T+22", done_cyc.size(),
                               done_cyc.size() > 0 ? done_cyc[0] - t : -1);
    end
    $display("[TB] test_waitrequest complete: %0d beats", beat_addr.size());
  endtask

  task automatic test_ignore_busy();
    logic [BLK-1:0] blk_a, blk_b, blk_c;
    int t;
    clear_log();
    blk_a = make_data(8'h03); blk_b = make_data(8'h04); blk_c = make_data(8'h05);
    baseaddr = 32'h0000_1000; index = 32'd2; data = blk_a; write = 1'b1;
    t = cyc;
    step();
    write = 1'b0;
    for (int i = 1; i <= 42; i++) begin
      if (i == 4) begin
        write = 1'b1; index = 32'd7; data = blk_b;
      end else if (i >= 10) begin
        write = (acc_cyc.size() < 2); index = 32'd7; data = blk_c;
      end else begin
        write = 1'b0;
      end
      step();
    end
    write = 1'b0;
    tests_run++;
    if (acc_cyc.size() != 2 || acc_cyc[1] != t + 20) begin
      tests_failed++; $display("FAIL busy_accepts count=%0d second=T+%0d exp=2@T+20", acc_cyc.size(),
                               acc_cyc.size() > 1 ? acc_cyc[1] - t : -1);
    end
    tests_run++;
    if (beat_addr.size() != 2 * NB) begin
      tests_failed++; $display("FAIL busy_beat_count got=%0d exp=%0d", beat_addr.size(), 2 * NB);
    end else begin
      tests_run++;
      if (beat_addr[NB-1] !== 32'h0000_1035 || beat_data[NB-1] !== blk_a[16*(NB-1) +: 16]) begin
        tests_failed++; $display("FAIL busy_first_last got=%h/%h exp=00001035/%h", beat_addr[NB-1], beat_data[NB-1],
                                 blk_a[16*(NB-1) +: 16]);
      end
      tests_run++;
      if (beat_addr[NB] !== 32'h0000_107E || beat_data[NB] !== blk_c[15:0] || beat_cyc[NB] != t + 21) begin
        tests_failed++; $display("FAIL busy_second_beat0 got=%h/%h@T+%0d exp=0000107e/%h@T+21", beat_addr[NB],
                                 beat_data[NB], beat_cyc[NB] - t, blk_c[15:0]);
      end
    end
    tests_run++;
    if (done_cyc.size() != 2) begin tests_failed++; $display("FAIL busy_done_count got=%0d exp=2", done_cyc.size()); end
    $display("[TB] test_ignore_busy complete: %0d accepts", acc_cyc.size());
  endtask

  task automatic test_reset_mid_block();
    int t;
    clear_log();
    baseaddr = 32'h0000_1000; index = 32'd4; data = make_data(8'h06); write = 1'b1;
    t = cyc;
    step();
    write = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (avm_m0_write !== 1'b0 || iready !== 1'b1) begin
      tests_failed++; $display("FAIL abort_next_cycle got write=%b iready=%b exp write=0 iready=1", avm_m0_write, iready);
    end
    for (int i = 0; i < 25; i++) step();
    tests_run++;
    if (done_cyc.size() != 0) begin tests_failed++; $display("FAIL abort_done pulses=%0d exp=0", done_cyc.size()); end
    tests_run++;
    if (beat_addr.size() != 9 || beat_cyc[7] != t + 8) begin
      tests_failed++; $display("FAIL abort_beats got=%0d exp=9", beat_addr.size());
    end
    $display("[TB] test_reset_mid_block complete: %0d beats before abort", beat_addr.size());
  endtask

  task automatic test_wrap();
    int t;
    clear_log();
    baseaddr = 32'hFFFF_FFF0; index = 32'd0; data = make_data(8'h07); write = 1'b1;
    t = cyc;
    step();
    write = 1'b0;
    for (int i = 1; i <= 21; i++) step();
    tests_run++;
    if (beat_addr.size() != NB) begin
      tests_failed++; $display("FAIL wrap_beat_count got=%0d exp=%0d", beat_addr.size(), NB);
    end else begin
      tests_run++;
      if (beat_addr[15] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_beat15 got=%h exp=ffffffff", beat_addr[15]); end
      tests_run++;
      if (beat_addr[16] !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_beat16 got=%h exp=00000000", beat_addr[16]); end
      tests_run++;
      if (beat_addr[17] !== 32'h0000_0001) begin tests_failed++; $display("FAIL wrap_beat17 got=%h exp=00000001", beat_addr[17]); end
    end
    tests_run++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 19) begin
      tests_failed++; $display("FAIL wrap_done pulses=%0d exp=1@T+19", done_cyc.size());
    end
    $display("[TB] test_wrap complete: %0d beats", beat_addr.size());
  endtask

  task automatic test_back_to_back();
    logic [BLK-1:0] blk_b;
    int t;
    clear_log();
    blk_b = make_data(8'h09);
    baseaddr = 32'h0000_1000; index = 32'd1; data = make_data(8'h08); write = 1'b1;
    t = cyc;
    step();
    index = 32'd3; data = blk_b;
    for (int i = 1; i <= 21; i++) begin
      if (i == 20) begin
        tests_run++;
        if (iready !== 1'b1 || avm_m0_write !== 1'b0) begin
          tests_failed++; $display("FAIL b2b_gap got iready=%b write=%b exp 1/0", iready, avm_m0_write);
        end
      end
      step();
    end
    write = 1'b0;
    for (int i = 0; i < 20; i++) step();
    tests_run++;
    if (acc_cyc.size() != 2 || acc_cyc[1] != t + 20) begin
      tests_failed++; $display("FAIL b2b_accepts count=%0d second=T+%0d exp=2@T+20", acc_cyc.size(),
                               acc_cyc.size() > 1 ? acc_cyc[1] - t : -1);
    end
    tests_run++;
    if (beat_addr.size() != 2 * NB || done_cyc.size() != 2) begin
      tests_failed++; $display("FAIL b2b_counts beats=%0d dones=%0d exp=%0d/2", beat_addr.size(), done_cyc.size(), 2 * NB);
    end else begin
      tests_run++;
      if (beat_cyc[NB] != done_cyc[0] + 2 || beat_addr[NB] !== 32'h0000_1036 || beat_data[NB] !== blk_b[15:0]) begin
        tests_failed++; $display("FAIL b2b_second_beat0 got=%h/%h gap=%0d exp=00001036/%h gap=2", beat_addr[NB],
                                 beat_data[NB], beat_cyc[NB] - done_cyc[0], blk_b[15:0]);
      end
    end
    $display("[TB] test_back_to_back complete: %0d beats", beat_addr.size());
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; baseaddr = '0; index = '0; data = '0;
    avm_m0_waitrequest = 1'b0; avm_m0_readdata = '0; avm_m0_readdatavalid = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_waitrequest();
    test_ignore_busy();
    test_reset_mid_block();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
